// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// 8N1 UART transmitter (LSB first) with a small byte FIFO in front of the
// serializer. Bit timing matches uart_rx: each serial bit lasts CLKS_PER_BIT
// clocks. All line-facing outputs are registered, so they trail the internal
// state machine by one clock; o_Tx_Done is aligned with the end of the stop
// bit as it appears on the pin.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 87,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Tx_DV,
    input  logic [7:0]                 i_Tx_Byte,
    output logic                       o_Tx_Ready,
    output logic                       o_Tx_Serial,
    output logic                       o_Tx_Active,
    output logic                       o_Tx_Done,
    output logic [FIFO_DEPTH_LOG2:0]   o_Fifo_Count
);

    // -----------------------------------------------------------------------
    // Derived sizes and width-exact constants
    // -----------------------------------------------------------------------
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CW-1:0]    FIFO_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0]    COUNT_ZERO = CW'(0);
    localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [CNT_W-1:0] CLK_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CLK_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLK_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_ZERO   = 3'd0;
    localparam logic [2:0]       BIT_ONE    = 3'd1;
    localparam logic [2:0]       BIT_LAST   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]    count_q,   count_d;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             done_flag_q, done_flag_d;

    logic             tx_serial_q, tx_serial_d;
    logic             tx_active_q, tx_active_d;
    logic             tx_done_q,   tx_done_d;

    logic             ready_s;
    logic             push_s;
    logic             pop_s;
    logic             bit_end_s;

    // -----------------------------------------------------------------------
    // Handshake decode: push only with space, pop only from IDLE
    // -----------------------------------------------------------------------
    // FIFO handshake qualifiers derived from the registered count and state.
    always_comb begin
        ready_s   = (count_q != FIFO_FULL);
        push_s    = i_Tx_DV && ready_s && !i_Reset;
        pop_s     = (state_q == ST_IDLE) && (count_q != COUNT_ZERO);
        bit_end_s = (clk_cnt_q == CLK_LAST);
    end

    // Next-state for FIFO pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and count registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO data array; contents need no reset because the pointers gate them.
    always_ff @(posedge i_Clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    // -----------------------------------------------------------------------
    // Serializer state machine
    // -----------------------------------------------------------------------
    // Next-state logic: bit timing, bit index, and loading the shift register.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        done_flag_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    shift_d   = mem_q[rd_ptr_q];
                    clk_cnt_d = CLK_ZERO;
                    bit_idx_d = BIT_ZERO;
                    state_d   = ST_START;
                end else begin
                    clk_cnt_d = CLK_ZERO;
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    clk_cnt_d = CLK_ZERO;
                    bit_idx_d = BIT_ZERO;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    clk_cnt_d = CLK_ZERO;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = BIT_ZERO;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    clk_cnt_d   = CLK_ZERO;
                    done_flag_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            default: begin
                clk_cnt_d = CLK_ZERO;
                bit_idx_d = BIT_ZERO;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Serializer state, counters and shift register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            done_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            done_flag_q <= done_flag_d;
        end
    end

    // -----------------------------------------------------------------------
    // Registered line outputs
    // -----------------------------------------------------------------------
    // Decode the pin level, activity and completion from the current state.
    always_comb begin
        tx_serial_d = 1'b1;
        tx_active_d = (state_q != ST_IDLE);
        tx_done_d   = done_flag_q;
        case (state_q)
            ST_IDLE:  tx_serial_d = 1'b1;
            ST_START: tx_serial_d = 1'b0;
            ST_DATA:  tx_serial_d = shift_q[bit_idx_q];
            ST_STOP:  tx_serial_d = 1'b1;
            default:  tx_serial_d = 1'b1;
        endcase
    end

    // Output registers; the line returns high the cycle after a reset edge.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign o_Tx_Ready   = ready_s;
    assign o_Tx_Serial  = tx_serial_q;
    assign o_Tx_Active  = tx_active_q;
    assign o_Tx_Done    = tx_done_q;
    assign o_Fifo_Count = count_q;

endmodule
